// File: rtl/hazard_controller.sv
// ID-stage hazard unit for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls, redirect flush, external memory hold, plus a saturating stall-cycle counter.
module hazard_controller #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             uses_rt_ID,
  input  logic             branch_ID,
  input  logic             branch_taken_ID,
  input  logic             jump_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] WriteReg_EX,
  input  logic             MemRead_MEM,
  input  logic [REG_W-1:0] WriteReg_MEM,
  input  logic             ext_hold,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic             bubble_EX,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic             w_lu, w_br_alu, w_br_ld, w_br_ldm;
  logic [1:0]       w_need;
  logic             w_stall, w_bubble, w_redirect;

  // $zero is hardwired, so a write to it never creates a dependency
  assign w_rs_ex  = (WriteReg_EX  == rs_ID) && (rs_ID != '0);
  assign w_rt_ex  = (WriteReg_EX  == rt_ID) && (rt_ID != '0);
  assign w_rs_mem = (WriteReg_MEM == rs_ID) && (rs_ID != '0);
  assign w_rt_mem = (WriteReg_MEM == rt_ID) && (rt_ID != '0);

  assign w_lu     = MemRead_EX && (w_rs_ex || (uses_rt_ID && w_rt_ex));
  assign w_br_alu = branch_ID && RegWrite_EX && !MemRead_EX && (w_rs_ex || w_rt_ex);
  assign w_br_ld  = branch_ID && MemRead_EX && (w_rs_ex || w_rt_ex);
  assign w_br_ldm = branch_ID && MemRead_MEM && (w_rs_mem || w_rt_mem);

  always_comb begin
    w_need = 2'd0;
    if (w_br_ld)
      w_need = 2'd2;
    else if (w_lu || w_br_alu || w_br_ldm)
      w_need = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    if (ext_hold) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_need != 2'd0) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            // a single-cycle hazard is simply re-detected next cycle
            if (w_need == 2'd2) begin
              w_state_nxt = HOLD;
              w_cnt_nxt   = 2'd1;
            end
          end
        end
        HOLD: begin
          w_stall   = 1'b1;
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 2'd0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= 2'd0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  // a branch waiting on operands must not redirect
  assign w_redirect = jump_ID || (branch_ID && branch_taken_ID);

  assign stall_IF    = reset && w_stall;
  assign stall_ID    = reset && w_stall;
  assign bubble_EX   = reset && w_bubble;
  assign flush_ID    = reset && w_redirect && !w_stall && !ext_hold;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic checked
// against a rule-level model of stall demand and pending stall cycles.
module tb_hazard_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_ID, rt_ID, WriteReg_EX, WriteReg_MEM;
  logic       uses_rt_ID, branch_ID, branch_taken_ID, jump_ID;
  logic       RegWrite_EX, MemRead_EX, MemRead_MEM, ext_hold;
  logic       stall_IF, stall_ID, flush_ID, bubble_EX;
  logic [15:0] stall_count;
  logic       s_stall_IF, s_stall_ID, s_flush_ID, s_bubble_EX;
  logic [3:0] s_stall_count;

  int n_vec = 0;
  int n_err = 0;
  int m_pend;
  int m_cnt;

  always #5 clk = ~clk;

  hazard_controller u_dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .branch_ID(branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .MemRead_MEM(MemRead_MEM), .WriteReg_MEM(WriteReg_MEM), .ext_hold(ext_hold),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .bubble_EX(bubble_EX), .stall_count(stall_count)
  );

  hazard_controller #(.REG_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .branch_ID(branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .MemRead_MEM(MemRead_MEM), .WriteReg_MEM(WriteReg_MEM), .ext_hold(ext_hold),
    .stall_IF(s_stall_IF), .stall_ID(s_stall_ID), .flush_ID(s_flush_ID),
    .bubble_EX(s_bubble_EX), .stall_count(s_stall_count)
  );

  function automatic bit hit(input logic [4:0] wr, input logic [4:0] r);
    return (wr == r) && (r != 5'd0);
  endfunction

  // stall cycles demanded by the instruction currently in ID
  function automatic int need_of();
    int n;
    n = 0;
    if (MemRead_EX && (hit(WriteReg_EX, rs_ID) || (uses_rt_ID && hit(WriteReg_EX, rt_ID)))) n = 1;
    if (branch_ID && RegWrite_EX && !MemRead_EX && (hit(WriteReg_EX, rs_ID) || hit(WriteReg_EX, rt_ID))) n = 1;
    if (branch_ID && MemRead_MEM && (hit(WriteReg_MEM, rs_ID) || hit(WriteReg_MEM, rt_ID))) n = (n > 1) ? n : 1;
    if (branch_ID && MemRead_EX && (hit(WriteReg_EX, rs_ID) || hit(WriteReg_EX, rt_ID))) n = 2;
    return n;
  endfunction

  task automatic clear_inputs();
    rs_ID = 0; rt_ID = 0; uses_rt_ID = 0; branch_ID = 0; branch_taken_ID = 0; jump_ID = 0;
    RegWrite_EX = 0; MemRead_EX = 0; WriteReg_EX = 0; MemRead_MEM = 0; WriteReg_MEM = 0;
    ext_hold = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    m_pend = 0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 3; rs_ID = 3; ext_hold = 1; jump_ID = 1;
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, flush_ID, bubble_EX} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outs got %b want 0000", {stall_IF, stall_ID, flush_ID, bubble_EX});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({stall_IF, stall_ID, flush_ID, bubble_EX} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_after_edge got %b cnt %0d want 0000 cnt 0",
                        {stall_IF, stall_ID, flush_ID, bubble_EX}, stall_count);
    end
    do_reset();
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, flush_ID, bubble_EX} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_release got %b cnt %0d", {stall_IF, stall_ID, flush_ID, bubble_EX}, stall_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 8; rs_ID = 8;
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, bubble_EX, flush_ID} !== 4'b1110) begin
      n_err++; $display("FAIL lu_stall got %b want 1110", {stall_IF, stall_ID, bubble_EX, flush_ID});
    end
    @(negedge clk);
    MemRead_EX = 0; RegWrite_EX = 0;
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, bubble_EX, flush_ID} !== 4'b0000 || stall_count !== 16'd1) begin
      n_err++; $display("FAIL lu_release got %b cnt %0d want 0000 cnt 1",
                        {stall_IF, stall_ID, bubble_EX, flush_ID}, stall_count);
    end
  endtask

  task automatic test_branch_load();
    do_reset();
    branch_ID = 1; rt_ID = 9; rs_ID = 2; MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 9;
    branch_taken_ID = 1;
    #1;
    n_vec++;
    if ({stall_ID, bubble_EX, flush_ID} !== 3'b110) begin
      n_err++; $display("FAIL brld_c1 got %b want 110", {stall_ID, bubble_EX, flush_ID});
    end
    @(negedge clk);
    MemRead_EX = 0; RegWrite_EX = 0; MemRead_MEM = 1; WriteReg_MEM = 9;
    #1;
    n_vec++;
    if ({stall_ID, bubble_EX, flush_ID} !== 3'b110) begin
      n_err++; $display("FAIL brld_c2 got %b want 110", {stall_ID, bubble_EX, flush_ID});
    end
    @(negedge clk);
    MemRead_MEM = 0;
    #1;
    n_vec++;
    if ({stall_ID, bubble_EX, flush_ID} !== 3'b001 || stall_count !== 16'd2) begin
      n_err++; $display("FAIL brld_flush got %b cnt %0d want 001 cnt 2", {stall_ID, bubble_EX, flush_ID}, stall_count);
    end
    @(negedge clk);
    branch_ID = 0; branch_taken_ID = 0;
    #1;
    n_vec++;
    if (flush_ID !== 1'b0) begin
      n_err++; $display("FAIL brld_flush_end got %b want 0", flush_ID);
    end
  endtask

  task automatic test_zero_rt();
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 0; rs_ID = 0; rt_ID = 0; branch_ID = 1; uses_rt_ID = 1;
    #1;
    n_vec++;
    if (stall_ID !== 1'b0) begin
      n_err++; $display("FAIL zero_reg got %b want 0", stall_ID);
    end
    @(negedge clk);
    branch_ID = 0; WriteReg_EX = 5; rt_ID = 5; uses_rt_ID = 0;
    #1;
    n_vec++;
    if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
      n_err++; $display("FAIL rt_unused got %b%b want 00", stall_ID, bubble_EX);
    end
    @(negedge clk);
    uses_rt_ID = 1;
    #1;
    n_vec++;
    if (stall_ID !== 1'b1 || bubble_EX !== 1'b1) begin
      n_err++; $display("FAIL rt_used got %b%b want 11", stall_ID, bubble_EX);
    end
  endtask

  task automatic test_ext_hold_in_hold();
    do_reset();
    branch_ID = 1; rs_ID = 7; MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 7;
    @(negedge clk);
    clear_inputs();
    ext_hold = 1; jump_ID = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({stall_IF, stall_ID, bubble_EX, flush_ID} !== 4'b1100 || stall_count !== 16'(1 + i)) begin
        n_err++; $display("FAIL ext_hold_%0d got %b cnt %0d want 1100 cnt %0d",
                          i, {stall_IF, stall_ID, bubble_EX, flush_ID}, stall_count, 1 + i);
      end
      @(negedge clk);
    end
    ext_hold = 0; jump_ID = 0;
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b111) begin
      n_err++; $display("FAIL ext_hold_resume got %b want 111", {stall_IF, stall_ID, bubble_EX});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b000 || stall_count !== 16'd5) begin
      n_err++; $display("FAIL ext_hold_done got %b cnt %0d want 000 cnt 5", {stall_IF, stall_ID, bubble_EX}, stall_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    branch_ID = 1; rt_ID = 4; MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 4;
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if (stall_ID !== 1'b1) begin
      n_err++; $display("FAIL mid_hold_pre got %b want 1", stall_ID);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({stall_IF, stall_ID, flush_ID, bubble_EX} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL mid_hold_reset got %b cnt %0d want 0000 cnt 0",
                        {stall_IF, stall_ID, flush_ID, bubble_EX}, stall_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if ({stall_IF, stall_ID, flush_ID, bubble_EX} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL mid_hold_idle got %b cnt %0d want 0000 cnt 0",
                        {stall_IF, stall_ID, flush_ID, bubble_EX}, stall_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ext_hold = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_vec++;
      if (s_stall_count !== 4'((i > 15) ? 15 : i)) begin
        n_err++; $display("FAIL sat_%0d got %0d want %0d", i, s_stall_count, (i > 15) ? 15 : i);
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (s_stall_count !== 4'd15 || stall_count !== 16'd20) begin
      n_err++; $display("FAIL sat_final got %0d/%0d want 15/20", s_stall_count, stall_count);
    end
    ext_hold = 0;
  endtask

  task automatic test_random();
    int need;
    bit e_stall, e_bubble, e_flush;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rs_ID = 5'($urandom_range(0, 3)); rt_ID = 5'($urandom_range(0, 3));
      WriteReg_EX = 5'($urandom_range(0, 3)); WriteReg_MEM = 5'($urandom_range(0, 3));
      uses_rt_ID = 1'($urandom); branch_ID = 1'($urandom); branch_taken_ID = 1'($urandom);
      jump_ID = ($urandom_range(0, 5) == 0); RegWrite_EX = 1'($urandom);
      MemRead_EX = ($urandom_range(0, 2) == 0); MemRead_MEM = ($urandom_range(0, 2) == 0);
      ext_hold = ($urandom_range(0, 4) == 0);
      #1;
      need = (m_pend > 0) ? 0 : need_of();
      e_stall = ext_hold || (m_pend > 0) || (need > 0);
      e_bubble = !ext_hold && ((m_pend > 0) || (need > 0));
      e_flush = (jump_ID || (branch_ID && branch_taken_ID)) && !e_stall;
      n_vec++;
      if ({stall_IF, stall_ID, bubble_EX, flush_ID} !== {e_stall, e_stall, e_bubble, e_flush} ||
          stall_count !== 16'(m_cnt)) begin
        n_err++; $display("FAIL rand_%0d got %b cnt %0d want %b cnt %0d", i,
                          {stall_IF, stall_ID, bubble_EX, flush_ID}, stall_count,
                          {e_stall, e_stall, e_bubble, e_flush}, m_cnt);
      end
      @(posedge clk);
      if (!ext_hold) begin
        if (m_pend > 0) m_pend--;
        else if (need == 2) m_pend = 1;
      end
      if (e_stall && m_cnt < 65535) m_cnt++;
    end
  endtask

  initial begin
    clear_inputs();
    m_pend = 0;
    m_cnt = 0;
    test_reset();
    test_load_use();
    test_branch_load();
    test_zero_rt();
    test_ext_hold_in_hold();
    test_reset_mid_hold();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
